// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC and selects the next PC (redirect, BTB target, PC+4).
// It issues imem requests, holds a fetched instruction during decode stalls and emits bubbles otherwise.
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH  = 64,
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk_i,
  input  logic                   arstn_i,
  input  logic                   stall_fetch_i,
  input  logic                   redirect_i,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
  input  logic                   bp_taken_i,
  input  logic [ADDR_WIDTH-1:0]  bp_target_i,
  input  logic [1:0]             bp_way_i,
  output logic                   imem_req_o,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  input  logic                   imem_ack_i,
  input  logic [INSTR_WIDTH-1:0] imem_instr_i,
  output logic                   fetch_busy_o,
  output logic                   log_trace_o,
  output logic                   branch_pred_taken_o,
  output logic [1:0]             btb_way_o,
  output logic [ADDR_WIDTH-1:0]  pc_target_addr_pred_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  pc_o,
  output logic [ADDR_WIDTH-1:0]  pc_plus4_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DROP  = 2'd3;

  localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(32'h0000_0013);

  logic [1:0]             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]  req_addr_q, req_addr_d;
  logic [INSTR_WIDTH-1:0] hold_instr_q, hold_instr_d;
  logic                   hold_taken_q, hold_taken_d;
  logic [ADDR_WIDTH-1:0]  hold_target_q, hold_target_d;
  logic [1:0]             hold_way_q, hold_way_d;

  logic                   valid;
  logic [INSTR_WIDTH-1:0] sel_instr;
  logic                   sel_taken;
  logic [ADDR_WIDTH-1:0]  sel_target;
  logic [1:0]             sel_way;
  logic [ADDR_WIDTH-1:0]  pc_plus4;

  assign pc_plus4 = pc_q + ADDR_WIDTH'(4);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    hold_instr_d  = hold_instr_q;
    hold_taken_d  = hold_taken_q;
    hold_target_d = hold_target_q;
    hold_way_d    = hold_way_q;
    imem_req_o    = 1'b0;
    imem_addr_o   = '0;
    fetch_busy_o  = 1'b0;
    valid         = 1'b0;
    sel_instr     = imem_instr_i;
    sel_taken     = bp_taken_i;
    sel_target    = bp_target_i;
    sel_way       = bp_way_i;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        imem_req_o   = 1'b1;
        imem_addr_o  = pc_q;
        req_addr_d   = pc_q;
        fetch_busy_o = !imem_ack_i;
        if (redirect_i) begin
          pc_d    = redirect_pc_i;
          state_d = imem_ack_i ? S_FETCH : S_DROP;
        end else if (imem_ack_i) begin
          valid = 1'b1;
          if (stall_fetch_i) begin
            hold_instr_d  = imem_instr_i;
            hold_taken_d  = bp_taken_i;
            hold_target_d = bp_target_i;
            hold_way_d    = bp_way_i;
            state_d       = S_HOLD;
          end else begin
            pc_d = bp_taken_i ? bp_target_i : pc_plus4;
          end
        end
      end

      S_HOLD: begin
        sel_instr  = hold_instr_q;
        sel_taken  = hold_taken_q;
        sel_target = hold_target_q;
        sel_way    = hold_way_q;
        if (redirect_i) begin
          pc_d    = redirect_pc_i;
          state_d = S_FETCH;
        end else begin
          valid = 1'b1;
          if (!stall_fetch_i) begin
            pc_d    = hold_taken_q ? hold_target_q : pc_plus4;
            state_d = S_FETCH;
          end
        end
      end

      default: begin // S_DROP: wait out the orphaned request, keeping its address stable
        imem_req_o   = 1'b1;
        imem_addr_o  = req_addr_q;
        fetch_busy_o = !imem_ack_i;
        if (redirect_i) pc_d = redirect_pc_i;
        if (imem_ack_i) state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      req_addr_q    <= RESET_PC;
      hold_instr_q  <= '0;
      hold_taken_q  <= 1'b0;
      hold_target_q <= '0;
      hold_way_q    <= '0;
    end else begin
      // NOTE: non-blocking updates so every register sees the pre-edge values of the others.
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_addr_q    <= req_addr_d;
      hold_instr_q  <= hold_instr_d;
      hold_taken_q  <= hold_taken_d;
      hold_target_q <= hold_target_d;
      hold_way_q    <= hold_way_d;
    end
  end

  assign log_trace_o           = valid;
  assign instr_o               = valid ? sel_instr : NOP;
  assign branch_pred_taken_o   = valid & sel_taken;
  assign btb_way_o             = valid ? sel_way : 2'b00;
  assign pc_target_addr_pred_o = valid ? sel_target : '0;
  assign pc_o                  = pc_q;
  assign pc_plus4_o            = pc_plus4;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that produces the PC, instruction and branch-prediction fields consumed by the fetch/decode pipeline register. It owns the architectural fetch PC and the next-PC selection (redirect, BTB-predicted target, PC+4). It issues requests on the instruction-memory port and holds a fetched instruction while decode is stalled. Invalid cycles are presented as bubbles.

## Interface
- ADDR_WIDTH, 64, PC/address width
- INSTR_WIDTH, 32, instruction width
- RESET_PC, 64'h0, first fetch address after reset
- clk_i  in  1  clock, rising edge
- arstn_i  in  1  reset, asynchronous, active-low
- stall_fetch_i  in  1  decode cannot accept; hold current instruction
- redirect_i  in  1  flush/mispredict redirect from execute
- redirect_pc_i  in  ADDR_WIDTH  redirect target
- bp_taken_i  in  1  BTB hit-and-taken for address pc_o (combinational lookup)
- bp_target_i  in  ADDR_WIDTH  BTB predicted target
- bp_way_i  in  2  BTB way of hit
- imem_req_o  out  1  instruction request valid
- imem_addr_o  out  ADDR_WIDTH  request address
- imem_ack_i  in  1  response valid; completes the outstanding request
- imem_instr_i  in  INSTR_WIDTH  instruction data, valid with imem_ack_i
- fetch_busy_o  out  1  request outstanding with no response this cycle
- log_trace_o  out  1  output fields carry a valid instruction
- branch_pred_taken_o  out  1  prediction for instr_o
- btb_way_o  out  2  BTB way for instr_o
- pc_target_addr_pred_o  out  ADDR_WIDTH  predicted target for instr_o
- instr_o  out  INSTR_WIDTH  instruction
- pc_o  out  ADDR_WIDTH  PC of instr_o
- pc_plus4_o  out  ADDR_WIDTH  pc_o + 4

## Operation
- Registers: pc_q, state, req_addr_q, hold buffer (instr, bp_taken, bp_target, bp_way).
- States: IDLE, FETCH, HOLD, DROP.
- IDLE: reset state; no request. Unconditionally goes to FETCH next cycle.
- FETCH: imem_req_o=1, imem_addr_o=pc_q; req_addr_q tracks pc_q.
  - No ack: fetch_busy_o=1, log_trace_o=0; pc_q is held.
  - Ack, no stall, no redirect: log_trace_o=1, instr_o=imem_instr_i, prediction fields=bp_*_i. pc_q <= bp_taken_i ? bp_target_i : pc_q+4. Stay in FETCH.
  - Ack with stall_fetch_i, no redirect: log_trace_o=1, fields from inputs. Capture instr and bp_* into the hold buffer. Go to HOLD; pc_q is held.
- HOLD: imem_req_o=0, log_trace_o=1, fields from the hold buffer, pc_o=pc_q. When stall_fetch_i=0: pc_q <= buffered taken ? buffered target : pc_q+4, then go to FETCH.
- DROP: entered on redirect while a request is outstanding without ack.
  - imem_req_o=1, imem_addr_o=req_addr_q (old address, kept stable), log_trace_o=0, fetch_busy_o=1.
  - On ack: discard the data, go to FETCH. pc_q already holds the redirect target.
- Redirect (priority over stall and ack, in any state except IDLE): pc_q <= redirect_pc_i and log_trace_o=0 that cycle.
  - From FETCH with ack, or from HOLD: go to FETCH, discard the data/buffer.
  - From FETCH without ack: go to DROP.
  - From DROP without ack: update pc_q and stay in DROP. From DROP with ack: go to FETCH.
- When log_trace_o=0: instr_o=32'h0000_0013 (NOP), branch_pred_taken_o=0, btb_way_o=0, pc_target_addr_pred_o=0. pc_o and pc_plus4_o still show pc_q.
- Arithmetic: pc_plus4_o = pc_o+4 modulo 2^ADDR_WIDTH (wraps, no flag). redirect_pc_i and bp_target_i are used unmodified.
- imem_addr_o is stable from request until ack.

## Timing
- Reset (async assert): state=IDLE, pc_q=RESET_PC, hold buffer=0. Outputs: imem_req_o=0, fetch_busy_o=0, log_trace_o=0, instr_o=NOP, pc_o=RESET_PC, pc_plus4_o=RESET_PC+4, all other outputs 0.
- First request is issued in the 2nd rising edge after deassertion (IDLE lasts one cycle).
- Zero-latency hit (ack in the request cycle): one valid instruction per cycle, sequential PCs, no bubbles.
- N-cycle memory latency: N-1 invalid cycles with fetch_busy_o=1, then one valid cycle.
- All outputs are combinational from state, registers, and the imem_*/bp_* inputs. The downstream register samples them at the next edge.
- Reset asserted mid-request or in HOLD/DROP: immediate return to reset values. The outstanding memory response is not tracked.

## Test plan
- Reset with RESET_PC=0x1000, ack tied high:
  - required: 1 idle cycle.
  - then log_trace_o=1 with pc_o 0x1000, 0x1004, 0x1008 on consecutive cycles.
  - pc_plus4_o=pc_o+4 each cycle.
- Ack delayed 3 cycles at pc 0x2000:
  - required: fetch_busy_o=1 and log_trace_o=0 for 2 cycles.
  - imem_addr_o=0x2000 throughout.
  - valid instruction on the 3rd cycle.
- bp_taken_i=1, bp_target_i=0x3000 at pc 0x2004 with ack: the next fetch address is 0x3000.
  - branch_pred_taken_o=1 and pc_target_addr_pred_o=0x3000 in the fetch cycle.
- Ack with stall_fetch_i=1 for 4 cycles, instr 0xDEADBEEF:
  - required: instr_o=0xDEADBEEF and log_trace_o=1 for the whole stall, imem_req_o=0.
  - pc advances only after the stall releases.
- redirect_i to 0x4000 while a miss at 0x2008 is outstanding:
  - required: DROP state with imem_addr_o=0x2008 until ack, log_trace_o=0, data discarded.
  - next request at 0x4000.
  - The same redirect asserted together with ack and stall_fetch_i → no HOLD, next request at 0x4000.
- pc_q=2^64-4 with ack:
  - required: pc_plus4_o=0.
  - next fetch address is 0.
